// File: rtl/wave_mixer.sv
// Multi-channel PCM sample player: once per output frame fetches one little-endian 16-bit
// sample per active channel, scales it by channel volume and mixes into a saturated output.
module wave_mixer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned CLK_HZ    = 24000000,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic                       I_CLK,
  input  logic                       I_RSTn,
  input  logic [CHANNELS*ADDR_W-1:0] I_BASE_ADDR,
  input  logic [CHANNELS*ADDR_W-1:0] I_LEN,
  input  logic [CHANNELS*8-1:0]      I_VOL,
  input  logic [CHANNELS-1:0]        I_LOOP,
  input  logic [CHANNELS-1:0]        I_TRIG,
  input  logic [CHANNELS-1:0]        I_STOP,
  input  logic                       I_PAUSE,
  output logic [ADDR_W-1:0]          O_ADDR,
  output logic                       O_READ,
  input  logic [7:0]                 I_DATA,
  input  logic                       I_READY,
  output logic [15:0]                O_PCM,
  output logic                       O_PCM_STB,
  output logic [CHANNELS-1:0]        O_ACTIVE,
  output logic                       O_OVERRUN
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CH_W  = $clog2(CHANNELS + 1);
  localparam int unsigned ACC_W = 24 + $clog2(CHANNELS);
  localparam int unsigned POS_W = ADDR_W + 2;

  localparam logic signed [ACC_W-1:0] PcmMax = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] PcmMin = ACC_W'(-32768);

  typedef enum logic [2:0] {
    StIdle,
    StReqLo,
    StWaitLo,
    StReqHi,
    StWaitHi,
    StAcc,
    StOut
  } state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q;
  logic                    tick;
  logic                    frame_start;
  logic [CHANNELS-1:0]     trig_pend_q, stop_pend_q;
  logic [CHANNELS-1:0]     active_q, active_d;
  logic [ADDR_W-1:0]       pos_q [CHANNELS];
  logic [ADDR_W-1:0]       pos_d [CHANNELS];
  logic [CH_W-1:0]         ch_q, ch_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [7:0]              lo_q, lo_d;
  logic signed [15:0]      sample_q, sample_d;
  logic                    have_q, have_d;
  logic                    first_q, first_d;
  logic [15:0]             pcm_q, pcm_d;
  logic                    stb_q, stb_d;
  logic                    overrun_q;

  logic [7:0]              vol_sel;
  logic signed [24:0]      prod;
  logic signed [24:0]      scaled;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CH_W-1:0]         start_ch;
  logic                    found;
  logic [CH_W-1:0]         next_ch;
  logic [ADDR_W-1:0]       next_addr;
  logic [POS_W-1:0]        next_pos;

  assign tick        = (div_q == DIV_W'(DIV - 1));
  assign frame_start = (state_q == StIdle) && tick;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Requests that arrive on the frame-start cycle itself carry over to the next frame.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      trig_pend_q <= '0;
      stop_pend_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      trig_pend_q <= (frame_start ? '0 : trig_pend_q) | I_TRIG;
      stop_pend_q <= (frame_start ? '0 : stop_pend_q) | I_STOP;
      overrun_q   <= tick && (state_q != StIdle);
    end
  end

  // Scale the sample just fetched for channel ch_q and add it to the running mix.
  always_comb begin
    vol_sel = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (CH_W'(n) == ch_q) vol_sel = I_VOL[n*8 +: 8];
    end
    prod    = 25'(sample_q) * 25'($signed({1'b0, vol_sel}));
    scaled  = prod >>> 7;
    acc_sum = have_q ? (acc_q + ACC_W'(scaled)) : acc_q;
  end

  // Lowest active channel at or above the scan point; nothing qualifies while paused.
  always_comb begin
    start_ch  = have_q ? (ch_q + CH_W'(1)) : ch_q;
    found     = 1'b0;
    next_ch   = '0;
    next_addr = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (!found && (CH_W'(n) >= start_ch) && active_q[n] && !I_PAUSE) begin
        found     = 1'b1;
        next_ch   = CH_W'(n);
        next_addr = I_BASE_ADDR[n*ADDR_W +: ADDR_W] + pos_q[n];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pos_d    = pos_q;
    ch_d     = ch_q;
    acc_d    = acc_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    sample_d = sample_q;
    have_d   = have_q;
    first_d  = 1'b0;
    pcm_d    = pcm_q;
    stb_d    = 1'b0;
    next_pos = '0;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          for (int n = 0; n < CHANNELS; n++) begin
            if (stop_pend_q[n]) begin
              active_d[n] = 1'b0;
            end else if (trig_pend_q[n] && (I_LEN[n*ADDR_W +: ADDR_W] >= ADDR_W'(2))) begin
              active_d[n] = 1'b1;
              pos_d[n]    = '0;
            end
          end
          acc_d   = '0;
          ch_d    = '0;
          have_d  = 1'b0;
          state_d = StAcc;
        end
      end

      StReqLo: begin
        first_d = 1'b1;
        state_d = StWaitLo;
      end

      // The cycle right after the request is a dead cycle for I_READY.
      StWaitLo: begin
        if (!first_q && I_READY) begin
          lo_d    = I_DATA;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StReqHi;
        end
      end

      StReqHi: begin
        first_d = 1'b1;
        state_d = StWaitHi;
      end

      StWaitHi: begin
        if (!first_q && I_READY) begin
          sample_d = $signed({I_DATA, lo_q});
          have_d   = 1'b1;
          state_d  = StAcc;
          for (int n = 0; n < CHANNELS; n++) begin
            if (CH_W'(n) == ch_q) begin
              next_pos = POS_W'(pos_q[n]) + POS_W'(2);
              if (next_pos + POS_W'(2) > POS_W'(I_LEN[n*ADDR_W +: ADDR_W])) begin
                if (I_LOOP[n]) begin
                  pos_d[n] = '0;
                end else begin
                  pos_d[n]    = ADDR_W'(next_pos);
                  active_d[n] = 1'b0;
                end
              end else begin
                pos_d[n] = ADDR_W'(next_pos);
              end
            end
          end
        end
      end

      StAcc: begin
        acc_d  = acc_sum;
        have_d = 1'b0;
        if (found) begin
          ch_d    = next_ch;
          addr_d  = next_addr;
          state_d = StReqLo;
        end else begin
          if (acc_sum > PcmMax) begin
            pcm_d = 16'h7fff;
          end else if (acc_sum < PcmMin) begin
            pcm_d = 16'h8000;
          end else begin
            pcm_d = acc_sum[15:0];
          end
          stb_d   = 1'b1;
          state_d = StOut;
        end
      end

      StOut: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q  <= StIdle;
      active_q <= '0;
      for (int n = 0; n < CHANNELS; n++) pos_q[n] <= '0;
      ch_q     <= '0;
      acc_q    <= '0;
      addr_q   <= '0;
      lo_q     <= '0;
      sample_q <= '0;
      have_q   <= 1'b0;
      first_q  <= 1'b0;
      pcm_q    <= '0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pos_q    <= pos_d;
      ch_q     <= ch_d;
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      lo_q     <= lo_d;
      sample_q <= sample_d;
      have_q   <= have_d;
      first_q  <= first_d;
      pcm_q    <= pcm_d;
      stb_q    <= stb_d;
    end
  end

  assign O_ADDR    = addr_q;
  assign O_READ    = (state_q == StReqLo) || (state_q == StReqHi);
  assign O_PCM     = pcm_q;
  assign O_PCM_STB = stb_q;
  assign O_ACTIVE  = active_q;
  assign O_OVERRUN = overrun_q;

endmodule

// File: tb/tb_wave_mixer.sv
// Directed bench for wave_mixer: two channels, 40-cycle frames, byte memory model with
// programmable response latency.
module tb_wave_mixer;

  localparam int unsigned CH = 2;
  localparam int unsigned AW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH*AW-1:0] base;
  logic [CH*AW-1:0] len;
  logic [CH*8-1:0] vol;
  logic [CH-1:0]   loop_en;
  logic [CH-1:0]   trig;
  logic [CH-1:0]   stop;
  logic            pause;
  logic [AW-1:0]   o_addr;
  logic            o_read;
  logic [7:0]      i_data = 8'h00;
  logic            i_ready = 1'b0;
  logic [15:0]     pcm;
  logic            stb;
  logic [CH-1:0]   active;
  logic            overrun;

  logic [7:0]      mem [0:4095];
  int              lat = 2;
  int              rd_cnt = 0;
  logic [AW-1:0]   rd_addr = '0;
  int              overlap_err = 0;

  int checks = 0;
  int errors = 0;

  wave_mixer #(
    .CHANNELS (CH),
    .ADDR_W   (AW),
    .CLK_HZ   (40),
    .SAMPLE_HZ(1)
  ) dut (
    .I_CLK      (clk),
    .I_RSTn     (rst_n),
    .I_BASE_ADDR(base),
    .I_LEN      (len),
    .I_VOL      (vol),
    .I_LOOP     (loop_en),
    .I_TRIG     (trig),
    .I_STOP     (stop),
    .I_PAUSE    (pause),
    .O_ADDR     (o_addr),
    .O_READ     (o_read),
    .I_DATA     (i_data),
    .I_READY    (i_ready),
    .O_PCM      (pcm),
    .O_PCM_STB  (stb),
    .O_ACTIVE   (active),
    .O_OVERRUN  (overrun)
  );

  always #5 clk = ~clk;

  // Memory: responds lat cycles after a request, holds I_READY until the next request.
  always @(negedge clk) begin
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        i_ready = 1'b1;
        i_data  = mem[rd_addr];
      end
    end
    if (o_read) begin
      if (rd_cnt > 0) overlap_err++;
      i_ready = 1'b0;
      rd_addr = o_addr;
      rd_cnt  = lat;
    end
  end

  typedef struct {
    logic [7:0]  v0;
    logic [7:0]  v1;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [1:0]  act;
    logic [15:0] exp_pcm;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_strobe();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!stb && k < 400);
    if (!stb) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout: no O_PCM_STB within %0d cycles", k);
    end
  endtask

  task automatic pulse(input logic [1:0] t, input logic [1:0] s);
    @(negedge clk);
    trig = t;
    stop = s;
    @(negedge clk);
    trig = '0;
    stop = '0;
  endtask

  task automatic stop_all();
    pulse(2'b00, 2'b11);
    wait_strobe();
    wait_strobe();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " O_READ"},    {31'd0, o_read},  32'd0);
    check({tag, " O_ADDR"},    {20'd0, o_addr},  32'd0);
    check({tag, " O_PCM"},     {16'd0, pcm},     32'd0);
    check({tag, " O_PCM_STB"}, {31'd0, stb},     32'd0);
    check({tag, " O_ACTIVE"},  {30'd0, active},  32'd0);
    check({tag, " O_OVERRUN"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int ov;
    int sc;
    int rd;
    logic [15:0] last;
    logic hi_seen;

    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    base    = {12'h200, 12'h100};
    len     = {12'd2, 12'd2};
    vol     = {8'd128, 8'd128};
    loop_en = 2'b00;
    trig    = 2'b00;
    stop    = 2'b00;
    pause   = 1'b0;

    vecs[0] = '{8'd128, 8'd128, 16'h7000, 16'h7000, 2'b11, 16'h7fff};
    vecs[1] = '{8'd128, 8'd128, 16'h9000, 16'h9000, 2'b11, 16'h8000};
    vecs[2] = '{8'd64,  8'd128, 16'h7000, 16'h7000, 2'b01, 16'h3800};
    vecs[3] = '{8'd128, 8'd128, 16'h1234, 16'h0100, 2'b11, 16'h1334};
    vecs[4] = '{8'd128, 8'd255, 16'h0000, 16'hffff, 2'b10, 16'hfffe};
    vecs[5] = '{8'd255, 8'd128, 16'h8000, 16'h0000, 2'b11, 16'h8000};
    vecs[6] = '{8'd0,   8'd128, 16'h4000, 16'h0100, 2'b11, 16'h0100};
    vecs[7] = '{8'd128, 8'd128, 16'h1234, 16'h1234, 2'b00, 16'h0000};
    vecs[8] = '{8'd3,   8'd3,   16'h0081, 16'hff7f, 2'b11, 16'hffff};

    // Reset state, then strobe timing of an empty frame relative to reset release.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 42; n++) begin
      @(posedge clk);
      #1;
      if (n >= 40) check($sformatf("empty frame stb edge %0d", n), {31'd0, stb}, {31'd0, n == 41});
    end
    check("empty frame pcm", {16'd0, pcm}, 32'd0);
    check("empty frame overrun", {31'd0, overrun}, 32'd0);

    // Mixing vectors: every channel plays a looped single sample.
    loop_en = 2'b11;
    for (int i = 0; i < 9; i++) begin
      stop_all();
      mem[12'h100] = vecs[i].s0[7:0];
      mem[12'h101] = vecs[i].s0[15:8];
      mem[12'h200] = vecs[i].s1[7:0];
      mem[12'h201] = vecs[i].s1[15:8];
      vol = {vecs[i].v1, vecs[i].v0};
      pulse(vecs[i].act, 2'b00);
      wait_strobe();
      wait_strobe();
      check($sformatf("vec%0d pcm", i), {16'd0, pcm}, {16'd0, vecs[i].exp_pcm});
      check($sformatf("vec%0d active", i), {30'd0, active}, {30'd0, vecs[i].act});
    end

    // One-shot playback of two samples.
    stop_all();
    loop_en = 2'b00;
    len     = {12'd2, 12'd4};
    vol     = {8'd128, 8'd128};
    mem[12'h100] = 8'h34;
    mem[12'h101] = 8'h12;
    mem[12'h102] = 8'hcd;
    mem[12'h103] = 8'hab;
    pulse(2'b01, 2'b00);
    wait_strobe();
    check("oneshot s0", {16'd0, pcm}, 32'h1234);
    check("oneshot active s0", {30'd0, active}, 32'd1);
    wait_strobe();
    check("oneshot s1", {16'd0, pcm}, 32'habcd);
    check("oneshot active end", {30'd0, active}, 32'd0);
    wait_strobe();
    check("oneshot silent", {16'd0, pcm}, 32'h0000);

    // Looped playback alternates indefinitely.
    loop_en = 2'b01;
    pulse(2'b01, 2'b00);
    for (int i = 0; i < 6; i++) begin
      wait_strobe();
      check($sformatf("loop s%0d", i), {16'd0, pcm}, (i % 2 == 0) ? 32'h1234 : 32'habcd);
      check($sformatf("loop active %0d", i), {30'd0, active}, 32'd1);
    end

    // Pause holds position: output silent, resumes with the following sample.
    wait_strobe();
    check("pre-pause", {16'd0, pcm}, 32'h1234);
    pause = 1'b1;
    wait_strobe();
    check("pause pcm a", {16'd0, pcm}, 32'h0000);
    check("pause active", {30'd0, active}, 32'd1);
    wait_strobe();
    check("pause pcm b", {16'd0, pcm}, 32'h0000);
    pause = 1'b0;
    wait_strobe();
    check("resume", {16'd0, pcm}, 32'habcd);

    // Stop wins over trigger in the same cycle.
    pulse(2'b10, 2'b10);
    wait_strobe();
    wait_strobe();
    check("trig+stop active", {30'd0, active}, 32'd1);

    // Slow memory: frames overrun, but one request at a time and the mix stays correct.
    stop_all();
    len     = {12'd2, 12'd2};
    loop_en = 2'b11;
    mem[12'h100] = 8'h00;
    mem[12'h101] = 8'h01;
    mem[12'h200] = 8'h00;
    mem[12'h201] = 8'h02;
    lat = 30;
    pulse(2'b11, 2'b00);
    ov   = 0;
    sc   = 0;
    last = 16'h0000;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (overrun) ov++;
      if (stb) begin
        sc++;
        last = pcm;
      end
    end
    check("overrun seen", {31'd0, ov > 0}, 32'd1);
    check("slow strobes seen", {31'd0, sc > 0}, 32'd1);
    check("slow mix", {16'd0, last}, 32'h0300);
    check("single outstanding", overlap_err, 32'd0);

    // Asynchronous reset while waiting for the high byte.
    hi_seen = 1'b0;
    for (int k = 0; k < 400 && !hi_seen; k++) begin
      @(negedge clk);
      if (o_read && o_addr[0]) hi_seen = 1'b1;
    end
    check("hi read seen", {31'd0, hi_seen}, 32'd1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_read) rd++;
    end
    check("post-reset reads", rd, 32'd0);
    check("post-reset active", {30'd0, active}, 32'd0);
    check("post-reset pcm", {16'd0, pcm}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wave_mixer.md
WAVE_MIXER -- requirements
Module: wave_mixer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent playback channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 28, byte-address width of the sample memory.
REQ-003 SHALL have parameter CLK_HZ, default 24000000, I_CLK frequency.
REQ-004 SHALL have parameter SAMPLE_HZ, default 48000, output sample rate; DIV = CLK_HZ/SAMPLE_HZ (integer, >= 8*CHANNELS+4).
REQ-005 SHALL have port I_CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port I_RSTn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port I_BASE_ADDR  in  CHANNELS*ADDR_W  per-channel start byte address, channel n at slice n.
REQ-008 SHALL have port I_LEN  in  CHANNELS*ADDR_W  per-channel length in bytes.
REQ-009 SHALL have port I_VOL  in  CHANNELS*8  per-channel unsigned gain, 128 = unity.
REQ-010 SHALL have port I_LOOP  in  CHANNELS  per-channel loop enable.
REQ-011 SHALL have port I_TRIG  in  CHANNELS  per-channel start pulse.
REQ-012 SHALL have port I_STOP  in  CHANNELS  per-channel stop pulse.
REQ-013 SHALL have port I_PAUSE  in  1  global pause level.
REQ-014 SHALL have port O_ADDR  out  ADDR_W  byte address to sample memory.
REQ-015 SHALL have port O_READ  out  1  one-cycle byte read request.
REQ-016 SHALL have port I_DATA  in  8  returned byte.
REQ-017 SHALL have port I_READY  in  1  memory data-valid level.
REQ-018 SHALL have port O_PCM  out  16  mixed signed sample.
REQ-019 SHALL have port O_PCM_STB  out  1  one-cycle pulse when O_PCM updates.
REQ-020 SHALL have port O_ACTIVE  out  CHANNELS  per-channel playing flag.
REQ-021 SHALL have port O_OVERRUN  out  1  one-cycle pulse on dropped tick.

Function
REQ-022 SHALL run a free counter 0..DIV-1 from reset; tick = counter==DIV-1.
REQ-023 SHALL latch I_TRIG/I_STOP bits into pending flags any cycle; pending flags SHALL be applied and cleared at the start of the next frame.
REQ-024 At frame start, pending STOP SHALL clear O_ACTIVE[n]; pending TRIG without STOP SHALL set position 0 and O_ACTIVE[n]=1 if I_LEN[n]>=2, else ignored; STOP wins over TRIG; TRIG on an active channel restarts it.
REQ-025 FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, ACC, OUT; tick in IDLE enters frame, channels visited in ascending index.
REQ-026 For each active channel (skipped if inactive or I_PAUSE=1), fetch low byte at base+pos then high byte at base+pos+1 (little-endian signed 16-bit).
REQ-027 Read handshake: O_READ high exactly one cycle with O_ADDR valid; O_ADDR SHALL hold until data captured; I_READY ignored in the O_READ cycle and the next; first later cycle with I_READY=1 captures I_DATA; only one request outstanding.
REQ-028 After fetch, pos += 2; if pos+2 > I_LEN[n]: I_LOOP[n]=1 -> pos=0, else O_ACTIVE[n]=0 (fetched sample still mixed).
REQ-029 ACC SHALL add (sample*vol)>>>7 (arithmetic) into an accumulator of 24+clog2(CHANNELS) bits, cleared at frame start.
REQ-030 OUT SHALL saturate the accumulator to [-32768, 32767], load O_PCM and pulse O_PCM_STB, then return to IDLE.
REQ-031 With no channel fetched (all inactive or paused), O_PCM SHALL be 0, O_PCM_STB two cycles after the tick.
REQ-032 I_PAUSE SHALL hold all positions and O_ACTIVE; pending flags still apply.
REQ-033 A tick arriving while not in IDLE SHALL be dropped and pulse O_OVERRUN; the current frame completes normally.
REQ-034 I_BASE_ADDR, I_LEN, I_VOL, I_LOOP SHALL be sampled when used, not latched.

Reset
REQ-035 On I_RSTn=0: FSM IDLE, divider 0, positions 0, pending flags 0, O_ACTIVE 0, O_PCM 0, O_PCM_STB 0, O_READ 0, O_ADDR 0, O_OVERRUN 0, asynchronously, including mid-fetch; an outstanding memory response after release SHALL be ignored.

Verification
REQ-036 CHANNELS=2, DIV=40, ch0 base 0x100 len 4 vol 128, memory 0x100..0x103 = 34 12 CD AB, TRIG0 -> O_PCM 0x1234 then 0xABCD on consecutive strobes, then O_ACTIVE[0]=0, O_PCM 0.
REQ-037 Same with I_LOOP[0]=1 -> O_PCM alternates 0x1234, 0xABCD indefinitely; O_ACTIVE[0] stays 1.
REQ-038 Both channels sample 0x7000, vol 128 -> O_PCM 0x7FFF (saturate); both 0x9000 -> 0x8000; ch0 vol 64 alone -> 0x3800.
REQ-039 I_TRIG[1] and I_STOP[1] same cycle -> O_ACTIVE[1] stays 0; I_PAUSE=1 mid-play -> O_PCM 0, position held, resumes same next sample on release.
REQ-040 Memory model delaying I_READY 30 cycles with DIV=40 and 2 active channels -> O_OVERRUN pulses, no second O_READ outstanding; I_RSTn low during WAIT_HI -> all outputs reset immediately.
